instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage: holds the PC, issues word reads to instruction memory, buffers
//  returned words, presents Instr[31:0]+PC to decode/Sign_Extend via valid/ready.
//  Handles branch/jump redirect with flush of buffered and in-flight words.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  BUF_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_l           in   1   async reset, active-low
//  imem_req        out  1   memory read request
//  imem_addr       out  32  word-aligned read address
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   read data valid (>=1 cycle after gnt)
//  imem_rdata      in   32  read data
//  redirect_valid  in   1   branch/jump taken, 1-cycle pulse
//  redirect_pc     in   32  redirect target
//  instr_valid     out  1   Instr/instr_pc valid
//  instr_ready     in   1   decode consumes this cycle
//  Instr           out  32  instruction word to decode/sign-extend
//  instr_pc        out  32  PC of Instr
//  fetch_fault     out  1   misaligned redirect (FETCH_MISALIGN_CHK_EN only)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, buffer empty, imem_req=0, imem_addr=0, instr_valid=0,
//    Instr=0, instr_pc=0, fetch_fault=0, state=BOOT. Reset mid-transfer drops all.
//  - FSM: BOOT -> RUN (1 cycle after reset release); RUN -> FLUSH on redirect with
//    granted-but-unreturned word; FLUSH -> RUN when that word's rvalid arrives
//    (word discarded); any -> HALT on fault (macro); HALT -> RUN on good redirect.
//  - Max one outstanding (granted, unreturned) request.
//  - Issue (RUN only): imem_req=1 when count+outstanding < BUF_DEPTH; imem_addr=pc.
//    req/addr held stable until gnt, even across redirect; req->gnt completes
//    on same edge, pc+=4 at gnt (32-bit wrap 0xFFFF_FFFC -> 0x0000_0000).
//  - Return: rvalid with outstanding and not discarding -> push {rdata, addr}.
//  - Output: head entry drives Instr/instr_pc; instr_valid=(count!=0). Pop on
//    valid&ready. Instr/instr_pc read 0 when instr_valid=0.
//  - Push+pop same cycle: count unchanged; empty buffer: no bypass (min latency
//    gnt->rvalid edge +1 cycle to instr_valid).
//  - Redirect (highest priority over pop/push): buffer cleared, instr_valid=0
//    next cycle, pc=redirect_pc; in-flight word marked discard. If req pending
//    ungranted, it completes to old addr and its data is discarded; the
//    redirect_pc request follows.
//  - Redirect with pop same cycle: pop counts as consumed; no other effect.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 -> fetch_fault=1 (sticky)
//    from next cycle, buffer flushed, state HALT, no requests until a redirect
//    with [1:0]==0 clears fault.
//  Undefined: redirect_pc[1:0] ignored (forced 2'b00); fetch_fault tied 0.
// STRUCTURE
//  Package fetch_pkg: fetch_state_e {BOOT,RUN,FLUSH,HALT}, WORD_BYTES=4,
//    NOP_INSTR=32'h0000_0013 (bench use).
//  Sub-module fetch_buf: BUF_DEPTH x 64-bit FIFO {pc,instr}, push/pop/clear,
//    count, async active-low reset.
// TESTING
//  1 Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> addrs 0,4,8...;
//    first instr_valid 3 cycles after reset release, Instr=mem[0], instr_pc=0.
//  2 ready=0 for 10 cycles -> exactly BUF_DEPTH words buffered, imem_req=0,
//    Instr/instr_pc stable; ready=1 -> in-order drain, no loss/duplication.
//  3 Redirect to 0x100 with word outstanding -> FLUSH, returned word dropped,
//    next instr_pc=0x100, Instr=mem[0x100>>2].
//  4 gnt held low 5 cycles during redirect -> imem_addr stable till gnt, its
//    data discarded, then req at 0x100.
//  5 Reset asserted mid-request -> all outputs 0 asynchronously; restart RESET_PC.
//  6 Macro on: redirect_pc=0x102 -> fetch_fault=1, no req; redirect 0x200
//    clears fault, fetch resumes at 0x200. Macro off: 0x102 fetches 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, instr} entries; clear has priority over push/pop.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != (PtrW+1)'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem reads, buffered valid/ready output, redirect flush.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets into a sticky fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, paddr_q, paddr_d, raddr_q, raddr_d;
  logic         pend_q, pend_d, pstale_q, pstale_d;
  logic         out_q, out_d, disc_q, disc_d, fault_q, fault_d;

  logic [CntW-1:0] count;
  fetch_entry_t    head, push_entry;
  logic            buf_push, buf_pop;
  logic            issue_new, grant, stale_now, ret, redir_bad;
  logic [31:0]     redir_target;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign redir_bad          = 1'b0;
  assign redir_target       = {redirect_pc[31:2], 2'b00};
`endif

  // A held (ungranted) request keeps req/addr stable regardless of state.
  always_comb begin
    issue_new = (state_q == RUN) && !pend_q && (!out_q || imem_rvalid) &&
                ((32'(count) + 32'(out_q)) < BUF_DEPTH);
    imem_req  = pend_q || issue_new;
    imem_addr = pend_q ? paddr_q : (issue_new ? pc_q : '0);
  end

  assign grant = imem_req && imem_gnt;
  assign ret   = out_q && imem_rvalid;
  // Word granted now belongs to the old stream if a redirect overtook it.
  assign stale_now = (pend_q && pstale_q) || redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    paddr_d  = paddr_q;
    raddr_d  = raddr_q;
    pend_d   = pend_q;
    pstale_d = pstale_q;
    out_d    = out_q;
    disc_d   = disc_q;
    fault_d  = fault_q;

    if (ret) begin
      out_d  = 1'b0;
      disc_d = 1'b0;
    end

    if (grant) begin
      out_d    = 1'b1;
      disc_d   = stale_now;
      raddr_d  = imem_addr;
      pend_d   = 1'b0;
      pstale_d = 1'b0;
      if (!stale_now) pc_d = pc_q + 32'(WORD_BYTES);
    end else if (imem_req) begin
      pend_d   = 1'b1;
      paddr_d  = imem_addr;
      pstale_d = stale_now;
    end

    if (redirect_valid) begin
      pc_d    = redir_target;
      fault_d = redir_bad;
      if (out_q && !imem_rvalid) disc_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:       state_d = RUN;
      RUN, FLUSH: state_d = (out_d && disc_d) ? FLUSH : RUN;
      HALT:       state_d = HALT;
      default:    state_d = BOOT;
    endcase
    if (redirect_valid && (state_q != BOOT)) begin
      if (redir_bad)                state_d = HALT;
      else if (out_d && disc_d)     state_d = FLUSH;
      else                          state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      paddr_q  <= '0;
      raddr_q  <= '0;
      pend_q   <= 1'b0;
      pstale_q <= 1'b0;
      out_q    <= 1'b0;
      disc_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      paddr_q  <= paddr_d;
      raddr_q  <= raddr_d;
      pend_q   <= pend_d;
      pstale_q <= pstale_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      fault_q  <= fault_d;
    end
  end

  assign buf_push   = ret && !disc_q && !redirect_valid;
  assign buf_pop    = instr_valid && instr_ready;
  assign push_entry = '{pc: raddr_q, instr: imem_rdata};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (rst_l),
    .clear_i (redirect_valid),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign Instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a stream-level reference model and imem responder.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready, fetch_fault;
  logic [31:0] Instr, instr_pc;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instr          (Instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a[3:2] == 2'b11) return NOP_INSTR;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: rvalid exactly lat cycles after the granting edge.
  int          lat = 1;
  logic        m_busy = 1'b0;
  int          m_cnt;
  logic [31:0] m_addr;
  logic        g_flag = 1'b0;
  logic [31:0] g_addr;
  logic [31:0] glog[$];

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_busy      = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (g_flag) begin
        m_busy = 1'b1;
        m_cnt  = lat;
        m_addr = g_addr;
      end
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(m_addr);
          m_busy      = 1'b0;
        end
      end
    end
  end

  // Stream model: accepted instructions must follow exp_pc, restarted by each redirect.
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] prev_addr;
  bit          halted = 0, expect_empty = 0, prev_stall = 0;

  always @(negedge clk) begin
    if (!rst_l) begin
      exp_pc = RESET_PC; halted = 0; expect_empty = 0; prev_stall = 0; g_flag = 1'b0;
      chk(!imem_req && imem_addr == 0 && !instr_valid && Instr == 0 && instr_pc == 0 &&
          !fetch_fault, "reset_outputs", imem_addr | Instr | instr_pc, 32'h0);
    end else begin
      if (expect_empty) chk(!instr_valid, "flush_empty", 32'(instr_valid), 32'h0);
      expect_empty = 0;
      if (!instr_valid) begin
        chk(Instr == 0 && instr_pc == 0, "idle_zero", Instr | instr_pc, 32'h0);
      end else if (instr_ready) begin
        chk(instr_pc == exp_pc, "stream_pc", instr_pc, exp_pc);
        chk(Instr == memf(exp_pc), "stream_instr", Instr, memf(exp_pc));
        exp_pc += 32'd4;
      end
      if (prev_stall)
        chk(imem_req && imem_addr == prev_addr, "req_hold", imem_addr, prev_addr);
      prev_stall = imem_req && !imem_gnt;
      prev_addr  = imem_addr;
      g_flag = imem_req && imem_gnt;
      g_addr = imem_addr;
      if (g_flag) begin
        chk(!m_busy, "one_outstanding", 32'(m_busy), 32'h0);
        glog.push_back(imem_addr);
      end
      if (halted)
        chk(fetch_fault && !imem_req && !instr_valid, "halted",
            {29'd0, fetch_fault, imem_req, instr_valid}, 32'h4);
      else
        chk(!fetch_fault, "no_fault", 32'(fetch_fault), 32'h0);
      if (redirect_valid) begin
        expect_empty = 1;
`ifdef FETCH_MISALIGN_CHK_EN
        halted = (redirect_pc[1:0] != 2'b00);
        exp_pc = redirect_pc;
`else
        exp_pc = {redirect_pc[31:2], 2'b00};
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] target);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, {name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    logic [31:0] snap_pc, snap_instr, held_addr;

    rst_l = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) step();
    glog.delete();
    rst_l = 1'b1;

    // 1: first instruction three edges after release
    @(negedge clk); chk(!imem_req && !instr_valid, "boot_idle", 32'(imem_req), 32'h0);
    @(negedge clk); chk(imem_req && imem_addr == 32'h0, "first_req", imem_addr, 32'h0);
    @(negedge clk); chk(!instr_valid, "latency_gap", 32'(instr_valid), 32'h0);
    @(negedge clk);
    chk(instr_valid && instr_pc == 32'h0, "first_valid_pc", instr_pc, 32'h0);
    chk(Instr == 32'hC0DE_0000, "first_instr", Instr, 32'hC0DE_0000);
    repeat (20) step();
    chk(glog.size() >= 3, "grant_count", glog.size(), 32'd3);
    if (glog.size() >= 3) begin
      chk(glog[1] == 32'h4, "addr_seq1", glog[1], 32'h4);
      chk(glog[2] == 32'h8, "addr_seq2", glog[2], 32'h8);
    end

    // 2: backpressure fills exactly BUF_DEPTH entries, then in-order drain
    instr_ready = 1'b0;
    repeat (3) step();
    snap_pc = instr_pc; snap_instr = Instr;
    repeat (7) step();
    @(negedge clk);
    chk(!imem_req, "full_no_req", 32'(imem_req), 32'h0);
    chk(instr_valid && instr_pc == snap_pc, "stall_pc_stable", instr_pc, snap_pc);
    chk(Instr == snap_instr, "stall_instr_stable", Instr, snap_instr);
    step();
    instr_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!instr_valid) break;
      run++;
    end
    chk(run == BUF_DEPTH, "buffered_words", 32'(run), 32'(BUF_DEPTH));

    // 3: redirect while a word is in flight
    lat = 3;
    repeat (6) step();
    for (int i = 0; i < 20; i++) begin
      if (m_busy) break;
      step();
    end
    chk(m_busy, "inflight_found", 32'(m_busy), 32'h1);
    redirect(32'h100);
    @(negedge clk); chk(!imem_req, "flush_no_req", 32'(imem_req), 32'h0);
    wait_valid("redir100");
    chk(instr_pc == 32'h100, "redir_pc", instr_pc, 32'h100);
    chk(Instr == 32'hC0DE_0100, "redir_instr", Instr, 32'hC0DE_0100);
    lat = 1;
    repeat (8) step();

    // 4: redirect while request is held ungranted
    imem_gnt = 1'b0;
    repeat (2) step();
    chk(imem_req, "held_req", 32'(imem_req), 32'h1);
    held_addr = imem_addr;
    redirect(32'h100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(imem_req && imem_addr == held_addr, "held_addr", imem_addr, held_addr);
    end
    step();
    glog.delete();
    imem_gnt = 1'b1;
    repeat (6) step();
    chk(glog.size() >= 2, "post_hold_grants", glog.size(), 32'd2);
    if (glog.size() >= 2) begin
      chk(glog[0] == held_addr, "stale_grant", glog[0], held_addr);
      chk(glog[1] == 32'h100, "new_target_req", glog[1], 32'h100);
    end
    repeat (6) step();

    // 5: asynchronous reset in the middle of a held request
    imem_gnt = 1'b0;
    repeat (3) step();
    rst_l = 1'b0;
    #1;
    chk(!imem_req && imem_addr == 0 && !instr_valid && Instr == 0 && instr_pc == 0,
        "async_reset", imem_addr | instr_pc, 32'h0);
    imem_gnt = 1'b1;
    repeat (2) step();
    glog.delete();
    rst_l = 1'b1;
    repeat (10) step();
    chk(glog.size() >= 2, "restart_grants", glog.size(), 32'd2);
    if (glog.size() >= 2) begin
      chk(glog[0] == RESET_PC, "restart_pc0", glog[0], RESET_PC);
      chk(glog[1] == RESET_PC + 32'h4, "restart_pc1", glog[1], RESET_PC + 32'h4);
    end

    // 6: misaligned redirect
    redirect(32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
    @(negedge clk);
    chk(fetch_fault && !imem_req, "fault_set", {31'd0, fetch_fault}, 32'h1);
    repeat (4) step();
    @(negedge clk);
    chk(fetch_fault && !imem_req && !instr_valid, "fault_sticky", 32'(fetch_fault), 32'h1);
    redirect(32'h200);
    @(negedge clk); chk(!fetch_fault, "fault_clear", 32'(fetch_fault), 32'h0);
    wait_valid("resume200");
    chk(instr_pc == 32'h200, "resume_pc", instr_pc, 32'h200);
    chk(Instr == 32'hC0DE_0200, "resume_instr", Instr, 32'hC0DE_0200);
`else
    wait_valid("align100");
    chk(instr_pc == 32'h100, "aligned_pc", instr_pc, 32'h100);
    chk(Instr == 32'hC0DE_0100, "aligned_instr", Instr, 32'hC0DE_0100);
    chk(!fetch_fault, "fault_tied", 32'(fetch_fault), 32'h0);
`endif
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
